l1_mem_arbiter: RTL

Two-port memory arbiter between the L1 instruction cache and the L1 data cache and the single shared lower-level memory port (L2 / physical memory). Accepts line-sized (256-bit) read requests from the I-side and read or write-back requests from the D-side. Grants exactly one requester at a time and holds the grant until the downstream response. Keeps per-side wait-cycle counters for the performance-counter block.

---
 rtl/l1_arb_pkg.sv | 25 ++
 rtl/arb_wait_counter.sv | 31 +++
 rtl/l1_mem_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/l1_arb_pkg.sv
// Shared types and width defaults for the L1 memory arbiter.
// The round-robin option is selected with the L1_ARB_RR_EN macro.
package l1_arb_pkg;

   localparam int DEFAULT_ADDR_W = 32;
   localparam int DEFAULT_LINE_W = 256;
   localparam int DEFAULT_CNT_W  = 32;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_SERVE_I = 2'd1,
      ARB_SERVE_D = 2'd2
   } arb_state_t;

   typedef enum logic {
      ARB_SIDE_I = 1'b0,
      ARB_SIDE_D = 1'b1
   } arb_side_t;

   // A D-side write-back counts as a request just like a read.
   function automatic logic d_side_request(input logic rd, input logic wr);
      return rd | wr;
   endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating wait-cycle counter with clear taking priority over increment.
// Used once per requester side by l1_mem_arbiter.
module arb_wait_counter
   import l1_arb_pkg::*;
#(
   parameter int CNT_W = DEFAULT_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_inc,
   input  logic             i_clear,
   output logic [CNT_W-1:0] o_count
);

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_inc && (r_count != '1)) begin
         r_count <= r_count + ONE;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/l1_mem_arbiter.sv
// Arbitrates line requests from the L1 I-cache and D-cache onto one memory port.
// Define L1_ARB_RR_EN for round-robin; otherwise the D-side has fixed priority.
module l1_mem_arbiter
   import l1_arb_pkg::*;
#(
   parameter int ADDR_W = DEFAULT_ADDR_W,
   parameter int LINE_W = DEFAULT_LINE_W,
   parameter int CNT_W  = DEFAULT_CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] i_address,
   input  logic              i_read,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic [ADDR_W-1:0] d_address,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic [ADDR_W-1:0] pmem_address,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp,
   input  logic              i_wait_clear,
   input  logic              d_wait_clear,
   output logic [CNT_W-1:0]  i_wait_count,
   output logic [CNT_W-1:0]  d_wait_count
);

   arb_state_t r_state;
   logic       w_iReq;
   logic       w_dReq;
   logic       w_dWins;

   assign w_iReq = i_read;
   assign w_dReq = d_side_request(d_read, d_write);

`ifdef L1_ARB_RR_EN
   arb_side_t r_lastGrant;

   // On a tie the side that was not served most recently goes next.
   assign w_dWins = w_dReq && (!w_iReq || (r_lastGrant == ARB_SIDE_I));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_lastGrant <= ARB_SIDE_I;
      end else if (r_state == ARB_IDLE) begin
         if (w_dWins) begin
            r_lastGrant <= ARB_SIDE_D;
         end else if (w_iReq) begin
            r_lastGrant <= ARB_SIDE_I;
         end
      end
   end
`else
   assign w_dWins = w_dReq;
`endif

   // Grants only from IDLE, so every transaction is followed by an IDLE cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ARB_IDLE;
      end else begin
         case (r_state)
            ARB_IDLE: begin
               if (w_dWins) begin
                  r_state <= ARB_SERVE_D;
               end else if (w_iReq) begin
                  r_state <= ARB_SERVE_I;
               end
            end
            ARB_SERVE_I, ARB_SERVE_D: begin
               if (pmem_resp) begin
                  r_state <= ARB_IDLE;
               end
            end
            default: r_state <= ARB_IDLE;
         endcase
      end
   end

   // A simultaneous read and write-back from the D-side is resolved as a write.
   always_comb begin
      pmem_address = '0;
      pmem_wdata   = '0;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      case (r_state)
         ARB_SERVE_I: begin
            pmem_address = i_address;
            pmem_read    = 1'b1;
         end
         ARB_SERVE_D: begin
            pmem_address = d_address;
            pmem_wdata   = d_wdata;
            pmem_read    = d_read & ~d_write;
            pmem_write   = d_write;
         end
         default: begin
         end
      endcase
   end

   assign i_resp  = pmem_resp & (r_state == ARB_SERVE_I);
   assign d_resp  = pmem_resp & (r_state == ARB_SERVE_D);
   assign i_rdata = pmem_rdata;
   assign d_rdata = pmem_rdata;

   arb_wait_counter #(.CNT_W(CNT_W)) u_iWait (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_inc   (w_iReq && (r_state != ARB_SERVE_I)),
      .i_clear (i_wait_clear),
      .o_count (i_wait_count)
   );

   arb_wait_counter #(.CNT_W(CNT_W)) u_dWait (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_inc   (w_dReq && (r_state != ARB_SERVE_D)),
      .i_clear (d_wait_clear),
      .o_count (d_wait_count)
   );

endmodule
